// File: rtl/decode_issue.sv
// Decode/issue stage: busy-scoreboard hazard stall, register bank read, ID/EX pipeline register.
// Optional: define DECODE_STALL_COUNT_EN to add a saturating 32-bit stall_cnt output.
module decode_issue #(
    parameter int INDEX_SIZE = 4,
    parameter int WIDTH      = 32,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INDEX_SIZE-1:0] in_ra,
    input  logic [INDEX_SIZE-1:0] in_rb,
    input  logic [INDEX_SIZE-1:0] in_rc,
    input  logic                  in_use_a,
    input  logic                  in_use_b,
    input  logic                  in_use_c,
    input  logic [INDEX_SIZE-1:0] in_rd,
    input  logic                  in_we,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [WIDTH-1:0]      in_imm,
    output logic [INDEX_SIZE-1:0] bank_ra,
    output logic [INDEX_SIZE-1:0] bank_rb,
    output logic [INDEX_SIZE-1:0] bank_rc,
    input  logic [WIDTH-1:0]      bank_rd1,
    input  logic [WIDTH-1:0]      bank_rd2,
    input  logic [WIDTH-1:0]      bank_rd3,
    input  logic                  wb_we,
    input  logic [INDEX_SIZE-1:0] wb_rd,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [WIDTH-1:0]      ex_op1,
    output logic [WIDTH-1:0]      ex_op2,
    output logic [WIDTH-1:0]      ex_op3,
    output logic [INDEX_SIZE-1:0] ex_rd,
    output logic                  ex_we,
    output logic [CTRL_W-1:0]     ex_ctrl,
`ifdef DECODE_STALL_COUNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [WIDTH-1:0]      ex_imm
);

    localparam int NREG = 2 ** INDEX_SIZE;

    logic [NREG-1:0]       busy_q, busy_d;
    logic [NREG-1:0]       wb_hit;
    logic [NREG-1:0]       eb;
    logic                  ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]      ex_op1_q, ex_op2_q, ex_op3_q;
    logic [INDEX_SIZE-1:0] ex_rd_q;
    logic                  ex_we_q;
    logic [CTRL_W-1:0]     ex_ctrl_q;
    logic [WIDTH-1:0]      ex_imm_q;

    logic hazard;
    logic adv;
    logic issue;
    logic new_we;

    // A writeback landing this cycle is already visible in the bank (negedge write),
    // so its register counts as free for hazard purposes.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_eb
        assign wb_hit[gi] = wb_we && (wb_rd == INDEX_SIZE'(gi));
        assign eb[gi]     = busy_q[gi] & ~wb_hit[gi];
    end

    assign new_we = in_we && (in_rd != '0);
    assign hazard = (in_use_a && eb[in_ra]) ||
                    (in_use_b && eb[in_rb]) ||
                    (in_use_c && eb[in_rc]) ||
                    (new_we   && eb[in_rd]);
    assign adv      = !ex_valid_q || ex_ready;
    assign in_ready = adv && !hazard && !flush;
    assign issue    = in_valid && in_ready;

    assign bank_ra = in_ra;
    assign bank_rb = in_rb;
    assign bank_rc = in_rc;

    // Clears are applied before the set so an issue to the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_we && (wb_rd != '0))
            busy_d[wb_rd] = 1'b0;
        if (flush && ex_valid_q && ex_we_q)
            busy_d[ex_rd_q] = 1'b0;
        if (issue && new_we)
            busy_d[in_rd] = 1'b1;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush)
            ex_valid_d = 1'b0;
        else if (issue)
            ex_valid_d = 1'b1;
        else if (ex_ready)
            ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_op3_q   <= '0;
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_imm_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            if (issue) begin
                ex_op1_q  <= bank_rd1;
                ex_op2_q  <= bank_rd2;
                ex_op3_q  <= bank_rd3;
                ex_rd_q   <= in_rd;
                ex_we_q   <= new_we;
                ex_ctrl_q <= in_ctrl;
                ex_imm_q  <= in_imm;
            end
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_op3   = ex_op3_q;
    assign ex_rd    = ex_rd_q;
    assign ex_we    = ex_we_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_imm   = ex_imm_q;

`ifdef DECODE_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && hazard && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed vector table, async-reset sequence, randomized run vs. model.
// Build with DECODE_STALL_COUNT_EN defined to also cover stall_cnt.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ra, in_rb, in_rc;
    logic        in_use_a, in_use_b, in_use_c;
    logic [3:0]  in_rd;
    logic        in_we;
    logic [7:0]  in_ctrl;
    logic [31:0] in_imm;
    logic [3:0]  bank_ra, bank_rb, bank_rc;
    logic [31:0] bank_rd1, bank_rd2, bank_rd3;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1, ex_op2, ex_op3;
    logic [3:0]  ex_rd;
    logic        ex_we;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_imm;
`ifdef DECODE_STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    decode_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_use_a(in_use_a), .in_use_b(in_use_b), .in_use_c(in_use_c),
        .in_rd(in_rd), .in_we(in_we), .in_ctrl(in_ctrl), .in_imm(in_imm),
        .bank_ra(bank_ra), .bank_rb(bank_rb), .bank_rc(bank_rc),
        .bank_rd1(bank_rd1), .bank_rd2(bank_rd2), .bank_rd3(bank_rd3),
        .wb_we(wb_we), .wb_rd(wb_rd), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_ctrl(ex_ctrl),
`ifdef DECODE_STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .ex_imm(ex_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Columns: inputs v,ra,rb,rc,ua,ub,uc,rd,we,d1,d2,d3,wbwe,wbrd,fl,exr;
    // expected e_rdy (before edge), e_v,e_op1,e_op2,e_rd,e_we (after edge).
    typedef struct {
        int unsigned v, ra, rb, rc, ua, ub, uc, rd, we, d1, d2, d3, wbwe, wbrd, fl, exr;
        int unsigned e_rdy, e_v, e_op1, e_op2, e_rd, e_we;
    } vec_t;

    vec_t tbl[19];

    // Behavioural reference state for the randomized run.
    bit          mbusy[16];
    bit          m_v;
    int unsigned m_op1, m_op2, m_op3, m_rd, m_we, m_ctrl, m_imm;
    int unsigned m_stall;

    function automatic bit eff_busy(input int r);
        return mbusy[r] && !(wb_we && int'(wb_rd) == r);
    endfunction

    task automatic clear_inputs();
        in_valid = 0; in_ra = 0; in_rb = 0; in_rc = 0;
        in_use_a = 0; in_use_b = 0; in_use_c = 0;
        in_rd = 0; in_we = 0; in_ctrl = 0; in_imm = 0;
        bank_rd1 = 0; bank_rd2 = 0; bank_rd3 = 0;
        wb_we = 0; wb_rd = 0; flush = 0; ex_ready = 0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply_row(input vec_t t);
        in_valid = 1'(t.v);
        in_ra = 4'(t.ra); in_rb = 4'(t.rb); in_rc = 4'(t.rc);
        in_use_a = 1'(t.ua); in_use_b = 1'(t.ub); in_use_c = 1'(t.uc);
        in_rd = 4'(t.rd); in_we = 1'(t.we);
        in_ctrl = 0; in_imm = 0;
        bank_rd1 = t.d1; bank_rd2 = t.d2; bank_rd3 = t.d3;
        wb_we = 1'(t.wbwe); wb_rd = 4'(t.wbrd);
        flush = 1'(t.fl); ex_ready = 1'(t.exr);
    endtask

    initial begin
        tbl[0]  = '{1, 1,2,0, 1,1,0,  3,1, 'h11,'h22,0, 0,0, 0,1,  1,1,'h11,'h22, 3,1};
        tbl[1]  = '{1, 3,0,0, 1,0,0,  4,1, 'h33,'h44,0, 0,0, 0,1,  0,0,0,0,0,0};
        tbl[2]  = '{1, 3,0,0, 1,0,0,  4,1, 'h33,'h44,0, 0,0, 0,1,  0,0,0,0,0,0};
        tbl[3]  = '{1, 3,0,0, 1,0,0,  4,1, 'h99,'h44,0, 1,3, 0,1,  1,1,'h99,'h44, 4,1};
        tbl[4]  = '{1, 0,0,0, 1,1,1,  0,1, 1,2,3,       0,0, 0,1,  1,1,1,2, 0,0};
        tbl[5]  = '{1, 0,0,0, 1,0,0,  0,1, 5,0,0,       0,0, 0,1,  1,1,5,0, 0,0};
        tbl[6]  = '{1, 1,0,0, 1,0,0,  6,1, 'h66,0,0,    0,0, 0,1,  1,1,'h66,0, 6,1};
        tbl[7]  = '{1, 2,0,0, 1,0,0,  5,1, 'h77,0,0,    0,0, 0,0,  0,1,'h66,0, 6,1};
        tbl[8]  = '{1, 2,0,0, 1,0,0,  5,1, 'h77,0,0,    0,0, 0,0,  0,1,'h66,0, 6,1};
        tbl[9]  = '{1, 2,0,0, 1,0,0,  5,1, 'h77,0,0,    0,0, 0,0,  0,1,'h66,0, 6,1};
        tbl[10] = '{1, 2,0,0, 1,0,0,  5,1, 'h77,0,0,    0,0, 0,1,  1,1,'h77,0, 5,1};
        tbl[11] = '{1, 1,0,0, 1,0,0,  8,1, 'h88,0,0,    0,0, 1,0,  0,0,0,0,0,0};
        tbl[12] = '{1, 5,0,0, 1,0,0,  9,1, 'h55,0,0,    0,0, 0,0,  1,1,'h55,0, 9,1};
        tbl[13] = '{1, 0,0,0, 0,0,0,  4,1, 'hAA,0,0,    0,0, 0,1,  0,0,0,0,0,0};
        tbl[14] = '{1, 0,0,0, 0,0,0,  4,1, 'hAA,0,0,    1,4, 0,1,  1,1,'hAA,0, 4,1};
        tbl[15] = '{1, 4,0,0, 1,0,0,  0,0, 'hBB,0,0,    0,0, 0,1,  0,0,0,0,0,0};
        tbl[16] = '{1, 4,0,0, 1,0,0, 10,1, 'hBB,0,0,    1,4, 0,1,  1,1,'hBB,0,10,1};
        tbl[17] = '{1, 1,0,0, 1,0,0, 11,1, 1,0,0,       0,0, 1,1,  0,0,0,0,0,0};
        tbl[18] = '{1,10,0,0, 1,0,0,  0,1, 'hCC,0,0,    0,0, 0,1,  1,1,'hCC,0, 0,0};

        // Reset state
        do_reset();
        #2;
        check("reset_ex_valid", 64'(ex_valid), 64'(0));
        check("reset_ex_op1",   64'(ex_op1),   64'(0));
        check("reset_ex_rd",    64'(ex_rd),    64'(0));
        check("reset_ex_we",    64'(ex_we),    64'(0));
        check("reset_ex_imm",   64'(ex_imm),   64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
`ifdef DECODE_STALL_COUNT_EN
        check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            apply_row(tbl[i]);
            #3;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ex_valid", i), 64'(ex_valid), 64'(tbl[i].e_v));
            if (tbl[i].e_v != 0) begin
                check($sformatf("vec%0d_ex_op1", i), 64'(ex_op1), 64'(tbl[i].e_op1));
                check($sformatf("vec%0d_ex_op2", i), 64'(ex_op2), 64'(tbl[i].e_op2));
                check($sformatf("vec%0d_ex_rd", i),  64'(ex_rd),  64'(tbl[i].e_rd));
                check($sformatf("vec%0d_ex_we", i),  64'(ex_we),  64'(tbl[i].e_we));
            end
            $display("vec %0d: in_ready=%0b ex_valid=%0b ex_op1=0x%0h ex_rd=%0d ex_we=%0b",
                     i, tbl[i].e_rdy[0], ex_valid, ex_op1, ex_rd, ex_we);
        end
`ifdef DECODE_STALL_COUNT_EN
        check("table_stall_cnt", 64'(stall_cnt), 64'(4));
`endif

        // Four hazard cycles, then asynchronous reset in the middle of a stall
        do_reset();
        in_valid = 1; in_ra = 1; in_use_a = 1; in_rd = 3; in_we = 1;
        bank_rd1 = 32'h1234; ex_ready = 1;
        #3;
        check("seq_issue_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_ra = 3; in_rd = 0; in_we = 0; ex_ready = 0;
        for (int k = 0; k < 4; k++) begin
            #3;
            check($sformatf("seq_stall%0d_ready", k), 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            $display("stall cycle %0d: in_ready=%0b ex_valid=%0b", k, in_ready, ex_valid);
        end
        check("seq_held_valid", 64'(ex_valid), 64'(1));
        check("seq_held_op1",   64'(ex_op1),   64'(32'h1234));
`ifdef DECODE_STALL_COUNT_EN
        check("seq_stall_cnt4", 64'(stall_cnt), 64'(4));
`endif
        #1 rst = 1'b1;
        #1;
        check("async_rst_ex_valid", 64'(ex_valid), 64'(0));
        check("async_rst_ex_op1",   64'(ex_op1),   64'(0));
        check("async_rst_in_ready", 64'(in_ready), 64'(1));
`ifdef DECODE_STALL_COUNT_EN
        check("async_rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized run against the reference model
        do_reset();
        for (int r = 0; r < 16; r++) mbusy[r] = 0;
        m_v = 0; m_stall = 0;
        m_op1 = 0; m_op2 = 0; m_op3 = 0; m_rd = 0; m_we = 0; m_ctrl = 0; m_imm = 0;
        for (int c = 0; c < 300; c++) begin
            bit hz, exp_rdy;
            in_valid = ($urandom_range(0, 4) != 0);
            in_ra = 4'($urandom_range(0, 7));
            in_rb = 4'($urandom_range(0, 7));
            in_rc = 4'($urandom_range(0, 7));
            in_use_a = 1'($urandom_range(0, 1));
            in_use_b = 1'($urandom_range(0, 1));
            in_use_c = ($urandom_range(0, 3) == 0);
            in_rd = 4'($urandom_range(0, 7));
            in_we = ($urandom_range(0, 3) != 0);
            in_ctrl = 8'($urandom);
            in_imm = $urandom;
            bank_rd1 = $urandom; bank_rd2 = $urandom; bank_rd3 = $urandom;
            wb_we = ($urandom_range(0, 2) == 0);
            wb_rd = 4'($urandom_range(0, 7));
            flush = ($urandom_range(0, 11) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);

            hz = (in_use_a && eff_busy(int'(in_ra))) || (in_use_b && eff_busy(int'(in_rb))) ||
                 (in_use_c && eff_busy(int'(in_rc))) ||
                 (in_we && in_rd != 0 && eff_busy(int'(in_rd)));
            exp_rdy = (!m_v || ex_ready) && !hz && !flush;
            #3;
            check($sformatf("rnd%0d_in_ready", c), 64'(in_ready), 64'(exp_rdy));
            check($sformatf("rnd%0d_bank_ra", c),  64'(bank_ra),  64'(in_ra));
            check($sformatf("rnd%0d_bank_rc", c),  64'(bank_rc),  64'(in_rc));

            if (in_valid && hz && !flush) m_stall++;
            if (wb_we && wb_rd != 0) mbusy[wb_rd] = 0;
            if (flush && m_v && m_we != 0) mbusy[m_rd] = 0;
            if (flush) begin
                m_v = 0;
            end else if (in_valid && exp_rdy) begin
                m_v = 1;
                m_op1 = bank_rd1; m_op2 = bank_rd2; m_op3 = bank_rd3;
                m_rd = int'(in_rd); m_we = (in_we && in_rd != 0) ? 1 : 0;
                m_ctrl = int'(in_ctrl); m_imm = in_imm;
                if (m_we != 0) mbusy[in_rd] = 1;
                $display("rnd %0d: issue rd=%0d we=%0d op1=0x%0h", c, m_rd, m_we, m_op1);
            end else if (ex_ready) begin
                m_v = 0;
            end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_ex_valid", c), 64'(ex_valid), 64'(m_v));
            if (m_v) begin
                check($sformatf("rnd%0d_ex_op1", c),  64'(ex_op1),  64'(m_op1));
                check($sformatf("rnd%0d_ex_op2", c),  64'(ex_op2),  64'(m_op2));
                check($sformatf("rnd%0d_ex_op3", c),  64'(ex_op3),  64'(m_op3));
                check($sformatf("rnd%0d_ex_rd", c),   64'(ex_rd),   64'(m_rd));
                check($sformatf("rnd%0d_ex_we", c),   64'(ex_we),   64'(m_we));
                check($sformatf("rnd%0d_ex_ctrl", c), 64'(ex_ctrl), 64'(m_ctrl));
                check($sformatf("rnd%0d_ex_imm", c),  64'(ex_imm),  64'(m_imm));
            end
        end
`ifdef DECODE_STALL_COUNT_EN
        check("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage placed directly upstream of the execute stage. It drives the 3-read-port register bank addresses and captures the bank read data into an ID/EX pipeline register.
- A per-register busy scoreboard stalls any instruction whose source or destination register has a writeback still pending (RAW and WAW hazards).
- The scoreboard is cleared by the same writeback signals (WE, Rd) that drive the register bank write port.

Parameters:
- INDEX_SIZE, 4, register index width; the bank holds 2**INDEX_SIZE registers.
- WIDTH, 32, datapath width.
- CTRL_W, 8, width of the opaque control bundle passed through to execute.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_ra, in_rb, in_rc  in  INDEX_SIZE  source register indices.
- in_use_a, in_use_b, in_use_c  in  1  corresponding source is actually read.
- in_rd  in  INDEX_SIZE  destination register index.
- in_we  in  1  instruction writes in_rd.
- in_ctrl  in  CTRL_W  control bundle.
- in_imm  in  WIDTH  extended immediate.
- bank_ra, bank_rb, bank_rc  out  INDEX_SIZE  register bank read addresses (combinational copy of in_ra/rb/rc).
- bank_rd1, bank_rd2, bank_rd3  in  WIDTH  register bank read data.
- wb_we, wb_rd  in  1, INDEX_SIZE  writeback strobe and index (same nets as bank WE/Rd).
- flush  in  1  discard the instruction held in the ID/EX register.
- ex_valid  out  1  ID/EX register holds an instruction.
- ex_ready  in  1  execute consumes ex_* this cycle.
- ex_op1, ex_op2, ex_op3  out  WIDTH  captured operands.
- ex_rd  out  INDEX_SIZE  destination index.
- ex_we  out  1  destination write enable.
- ex_ctrl  out  CTRL_W  control bundle.
- ex_imm  out  WIDTH  immediate.

Behaviour:
- State: busy[2**INDEX_SIZE-1:0]; ID/EX register (ex_valid plus all ex_* fields).
- Reset: busy=0, ex_valid=0, all ex_* outputs=0. Reset mid-operation drops everything. Later writebacks for pre-reset instructions only clear already-zero bits, which is harmless.
- Register 0: never marked busy, never causes a stall. ex_we = in_we & (in_rd!=0).
- Effective busy: eb[r] = busy[r] & !(wb_we & wb_rd==r). The bank writes on negedge, so data written in cycle N is readable before the posedge closing cycle N (writeback bypass).
- hazard = (in_use_a & eb[in_ra]) | (in_use_b & eb[in_rb]) | (in_use_c & eb[in_rc]) | (in_we & in_rd!=0 & eb[in_rd]).
- adv = !ex_valid | ex_ready.
- in_ready = adv & !hazard & !flush. It is combinational and does not depend on in_valid.
- Issue when in_valid & in_ready: at posedge, load ex_* from in_* and bank_rd1..3, set ex_valid=1, and set busy[in_rd] if ex_we.
- No issue but ex_ready: ex_valid=0. ex_* data holds its value (don't care).
- flush: ex_valid=0 at posedge. If the held instruction had ex_valid & ex_we, clear busy[ex_rd]. No issue occurs in a flush cycle.
- Writeback: wb_we & wb_rd!=0 clears busy[wb_rd] at posedge.
- Same-cycle set and clear on one index: set wins.
- Latency: 1 cycle from issue to ex_valid. Full throughput when there are no hazards and ex_ready=1.
- Stall holds ID/EX contents stable while ex_valid & !ex_ready.

Optional Feature:
- Macro DECODE_STALL_COUNT_EN.
- Defined: adds output stall_cnt [31:0], reset to 0. It increments at posedge when in_valid & hazard & !flush, and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then issue rd=3 we=1 ra=1 rb=2 with bank_rd1=0x11, bank_rd2=0x22 -> next cycle ex_valid=1, ex_op1=0x11, ex_op2=0x22, ex_we=1, busy[3]=1.
- Next instruction uses ra=3 while busy[3]=1 and no writeback -> in_ready=0 and it stays 0 each cycle. When wb_we=1, wb_rd=3 -> in_ready=1 in that same cycle, and the instruction issues with the bank data.
- Writes to rd=0 and reads of r0 -> never stall, ex_we=0, busy stays 0.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* held constant, in_ready=0. Then ex_ready=1 -> the next instruction loads.
- Held instruction rd=5 we=1 with flush=1 -> ex_valid=0, busy[5]=0, and in_ready=0 during the flush cycle.
- With DECODE_STALL_COUNT_EN, 4 hazard cycles -> stall_cnt=4. Assert rst mid-stall -> stall_cnt=0, busy=0, ex_valid=0 immediately (async).
